// File: rtl/fc_operand_loader.sv
// Stream-to-parallel operand loader for the fully-connected layer; returns the settled layer output.
// Optional frame framing check is enabled with `define FC_FRAME_CHECK_EN (adds s_last / frame_err).
module fc_operand_loader #(
  parameter int unsigned IP_LAYER      = 8,
  parameter int unsigned NUM_INP       = 8,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               s_valid,
  input  logic signed [15:0]                 s_data,
  output logic                               s_ready,
`ifdef FC_FRAME_CHECK_EN
  input  logic                               s_last,
  output logic                               frame_err,
`endif
  output logic [16*IP_LAYER*NUM_INP-1:0]     inputs_flat,
  output logic [16*IP_LAYER*NUM_INP-1:0]     weights_flat,
  output logic [16*IP_LAYER-1:0]             dense_wt_flat,
  output logic [15:0]                        bias,
  input  logic signed [15:0]                 ot,
  output logic                               res_valid,
  output logic [15:0]                        res_data,
  input  logic                               res_ready,
  output logic                               busy
);

  localparam int unsigned W     = 16;
  localparam int unsigned ARR_N = IP_LAYER * NUM_INP;
  localparam int unsigned IDX_W = (ARR_N > 1) ? $clog2(ARR_N) : 1;
  localparam int unsigned DW_W  = (IP_LAYER > 1) ? $clog2(IP_LAYER) : 1;
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    LD_IN   = 3'd0,
    LD_WT   = 3'd1,
    LD_DW   = 3'd2,
    LD_BIAS = 3'd3,
    SETTLE  = 3'd4,
    RESULT  = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [SET_W-1:0]   set_q, set_d;

  logic [ARR_N-1:0][W-1:0]    in_q, wt_q;
  logic [IP_LAYER-1:0][W-1:0] dw_q;
  logic [W-1:0]               bias_q;
  logic [W-1:0]               res_data_q, res_data_d;
  logic                       res_valid_q, res_valid_d;
  logic                       s_ready_q, s_ready_d;
  logic                       busy_q, busy_d;
  logic                       err_q, err_d;
  logic                       wr_in, wr_wt, wr_dw, wr_bias;

  logic xfer;
  logic abort;
  logic bias_err;

  assign xfer = s_valid && s_ready_q;

`ifdef FC_FRAME_CHECK_EN
  // An early s_last drops the word and restarts the frame; a bias without s_last is only flagged.
  assign abort    = xfer && s_last && (state_q != LD_BIAS);
  assign bias_err = xfer && !s_last && (state_q == LD_BIAS);
`else
  assign abort    = 1'b0;
  assign bias_err = 1'b0;
`endif

  // State, counters and all registered outputs/operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LD_IN;
      cnt_q       <= '0;
      set_q       <= '0;
      in_q        <= '0;
      wt_q        <= '0;
      dw_q        <= '0;
      bias_q      <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      s_ready_q   <= 1'b1;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      set_q       <= set_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      s_ready_q   <= s_ready_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      if (wr_in)   in_q[cnt_q]          <= s_data;
      if (wr_wt)   wt_q[cnt_q]          <= s_data;
      if (wr_dw)   dw_q[DW_W'(cnt_q)]   <= s_data;
      if (wr_bias) bias_q               <= s_data;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    set_d   = set_q;
    case (state_q)
      LD_IN, LD_WT, LD_DW: begin
        if (abort) begin
          state_d = LD_IN;
          cnt_d   = '0;
        end else if (xfer) begin
          if ((state_q != LD_DW && cnt_q == IDX_W'(ARR_N - 1)) ||
              (state_q == LD_DW && cnt_q == IDX_W'(IP_LAYER - 1))) begin
            state_d = (state_q == LD_IN) ? LD_WT : (state_q == LD_WT) ? LD_DW : LD_BIAS;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      LD_BIAS: begin
        if (xfer) begin
          state_d = SETTLE;
          cnt_d   = '0;
          set_d   = SET_W'(SETTLE_CYCLES);
        end
      end
      SETTLE: begin
        if (set_q == '0) begin
          state_d = RESULT;
        end else begin
          set_d = set_q - SET_W'(1);
        end
      end
      RESULT: begin
        if (res_valid_q && res_ready) begin
          state_d = LD_IN;
        end
      end
      default: begin
        state_d = LD_IN;
        cnt_d   = '0;
      end
    endcase
  end

  // Output and write-enable decode; flagged values are registered above.
  always_comb begin
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    err_d       = abort || bias_err;
    wr_in       = xfer && !abort && (state_q == LD_IN);
    wr_wt       = xfer && !abort && (state_q == LD_WT);
    wr_dw       = xfer && !abort && (state_q == LD_DW);
    wr_bias     = xfer && (state_q == LD_BIAS);
    if (state_q == SETTLE && set_q == '0) begin
      res_data_d  = ot;
      res_valid_d = 1'b1;
    end else if (state_q == RESULT && res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
    s_ready_d = (state_d == LD_IN) || (state_d == LD_WT) ||
                (state_d == LD_DW) || (state_d == LD_BIAS);
    busy_d    = !((state_d == LD_IN) && (cnt_d == '0));
  end

  assign s_ready       = s_ready_q;
  assign inputs_flat   = in_q;
  assign weights_flat  = wt_q;
  assign dense_wt_flat = dw_q;
  assign bias          = bias_q;
  assign res_valid     = res_valid_q;
  assign res_data      = res_data_q;
  assign busy          = busy_q;
`ifdef FC_FRAME_CHECK_EN
  assign frame_err     = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_fc_operand_loader.sv
// Randomized self-checking bench for fc_operand_loader against a frame-level reference model.
module tb_fc_operand_loader;

  localparam int IPL = 8;
  localparam int NI  = 8;
  localparam int SC  = 2;
  localparam int A   = IPL * NI;
  localparam int N   = 2 * A + IPL + 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  s_valid;
  logic [15:0]           s_data;
  logic                  s_ready;
  logic [16*A-1:0]       inputs_flat;
  logic [16*A-1:0]       weights_flat;
  logic [16*IPL-1:0]     dense_wt_flat;
  logic [15:0]           bias;
  logic [15:0]           ot;
  logic                  res_valid;
  logic [15:0]           res_data;
  logic                  res_ready;
  logic                  busy;
`ifdef FC_FRAME_CHECK_EN
  logic                  s_last;
  logic                  frame_err;
  bit                    use_last;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] frame [N];

  always #5 clk = ~clk;

  fc_operand_loader #(.IP_LAYER(IPL), .NUM_INP(NI), .SETTLE_CYCLES(SC)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
`ifdef FC_FRAME_CHECK_EN
    .s_last        (s_last),
    .frame_err     (frame_err),
`endif
    .inputs_flat   (inputs_flat),
    .weights_flat  (weights_flat),
    .dense_wt_flat (dense_wt_flat),
    .bias          (bias),
    .ot            (ot),
    .res_valid     (res_valid),
    .res_data      (res_data),
    .res_ready     (res_ready),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word with optional random idle cycles; returns once it has been accepted.
  task automatic send_word(input logic [15:0] w, input int gap_pct, output bit ok);
    bit taken;
    int waited;
    while (int'($urandom_range(99)) < gap_pct) begin
      s_valid = 1'b0;
      s_data  = 16'($urandom);
      tick();
    end
    s_valid = 1'b1;
    s_data  = w;
    taken   = 1'b0;
    waited  = 0;
    ok      = 1'b1;
    while (!taken) begin
      taken = s_ready;
      tick();
      if (!taken) begin
        waited++;
        if (waited > 50) begin
          check("s_ready_timeout", 32'd0, 32'd1);
          ok = 1'b0;
          break;
        end
      end
    end
    s_valid = 1'b0;
  endtask

  // Operands must equal the frame at fixed offsets: inputs, then weights, then dense, then bias.
  task automatic check_operands(input string tag);
    for (int k = 0; k < A; k++) begin
      check($sformatf("%s_in[%0d]", tag, k), 32'(inputs_flat[16*k +: 16]), 32'(frame[k]));
      check($sformatf("%s_wt[%0d]", tag, k), 32'(weights_flat[16*k +: 16]), 32'(frame[A+k]));
    end
    for (int k = 0; k < IPL; k++)
      check($sformatf("%s_dw[%0d]", tag, k), 32'(dense_wt_flat[16*k +: 16]), 32'(frame[2*A+k]));
    check($sformatf("%s_bias", tag), 32'(bias), 32'(frame[N-1]));
  endtask

  task automatic load_frame(input int gap_pct, input logic [15:0] res_val);
    bit ok;
    int lat;
    for (int i = 0; i < N; i++) begin
`ifdef FC_FRAME_CHECK_EN
      s_last = use_last && (i == N - 1);
`endif
      ot = 16'($urandom);
      send_word(frame[i], gap_pct, ok);
      if (!ok) return;
    end
`ifdef FC_FRAME_CHECK_EN
    s_last = 1'b0;
    check("frame_err_bias", 32'(frame_err), 32'(!use_last));
`endif
    ot = res_val;
    check("s_ready_settle", 32'(s_ready), 32'd0);
    check("busy_settle", 32'(busy), 32'd1);
    check("res_valid_early", 32'(res_valid), 32'd0);
    check_operands("load");
    s_valid = 1'b1;
    s_data  = 16'h7FFF;
    lat = 0;
    while (!res_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(SC + 1));
    check("res_data", 32'(res_data), 32'(res_val));
    ot = 16'($urandom);
  endtask

  task automatic drain(input int hold, input logic [15:0] res_val);
    for (int c = 0; c < hold; c++) begin
      tick();
      check("hold_s_ready", 32'(s_ready), 32'd0);
      check("hold_res_valid", 32'(res_valid), 32'd1);
      check("hold_res_data", 32'(res_data), 32'(res_val));
    end
    check_operands("hold");
    s_valid   = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("drain_res_valid", 32'(res_valid), 32'd0);
    check("drain_s_ready", 32'(s_ready), 32'd1);
    check("drain_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in"},   32'(|inputs_flat), 32'd0);
    check({tag, "_wt"},   32'(|weights_flat), 32'd0);
    check({tag, "_dw"},   32'(|dense_wt_flat), 32'd0);
    check({tag, "_bias"}, 32'(bias), 32'd0);
    check({tag, "_rd"},   32'(res_data), 32'd0);
    check({tag, "_rv"},   32'(res_valid), 32'd0);
    check({tag, "_rdy"},  32'(s_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    bit ok;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; ot = '0; res_ready = 1'b0;
`ifdef FC_FRAME_CHECK_EN
    s_last = 1'b0; use_last = 1'b1;
`endif
    tick(); tick();
    rst = 1'b0;
    check_reset_state("reset");

    // Directed frame: words 1..N, no gaps, layer output -42.
    for (int i = 0; i < N; i++) frame[i] = 16'(i + 1);
    load_frame(0, 16'hFFD6);
    check("in0", 32'(inputs_flat[15:0]), 32'd1);
    check("wt0", 32'(weights_flat[15:0]), 32'd65);
    check("dw7", 32'(dense_wt_flat[16*7 +: 16]), 32'd136);
    check("bias137", 32'(bias), 32'd137);
    drain(10, 16'hFFD6);

    // Back-to-back random frames with idle gaps.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) frame[i] = 16'($urandom);
      r = 16'($urandom);
      load_frame(30, r);
      drain(int'($urandom_range(0, 3)), r);
    end

    // Reset in the middle of a frame.
    for (int i = 0; i < N; i++) frame[i] = 16'($urandom);
    for (int i = 0; i < 70; i++) send_word(frame[i], 20, ok);
    check("busy_mid", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("midrst");
    for (int i = 0; i < N; i++) frame[i] = 16'($urandom);
    r = 16'($urandom);
    load_frame(10, r);
    drain(2, r);

`ifdef FC_FRAME_CHECK_EN
    // Early s_last: word dropped, frame restarts.
    begin
      logic [15:0] prev9;
      prev9 = frame[9];
      for (int i = 0; i < N; i++) frame[i] = 16'($urandom);
      for (int i = 0; i < 10; i++) begin
        s_last = (i == 9);
        send_word(frame[i], 0, ok);
      end
      s_last = 1'b0;
      check("abort_err", 32'(frame_err), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_in0", 32'(inputs_flat[15:0]), 32'(frame[0]));
      check("abort_in9", 32'(inputs_flat[16*9 +: 16]), 32'(prev9));
      tick();
      check("abort_err_pulse", 32'(frame_err), 32'd0);
    end
    use_last = 1'b1;
    r = 16'($urandom);
    load_frame(10, r);
    drain(1, r);
    use_last = 1'b0;
    for (int i = 0; i < N; i++) frame[i] = 16'($urandom);
    r = 16'($urandom);
    load_frame(10, r);
    drain(1, r);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fc_operand_loader.md
Name: fc_operand_loader

Overview:
- Streaming front end for the combinational fully-connected layer. Accepts one 16-bit word per handshake and deserializes a full frame into the parallel input, weight, dense-weight and bias operands.
- Holds the operands stable while the layer output settles, then captures `ot` and returns it on a valid/ready result channel.
- Sits between the DMA/stream source and the fc layer. It is the writer side of that layer's parallel operand interface.

Parameters:
- IP_LAYER, 8, number of hidden neurons (dense_wt entries).
- NUM_INP, 8, inputs per neuron; input and weight arrays hold IP_LAYER*NUM_INP words each.
- SETTLE_CYCLES, 2, cycles to wait after the bias load before sampling `ot` (minimum 1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  stream word valid.
- s_data  in  16  signed operand word.
- s_ready  out  1  loader can accept a word.
- inputs_flat  out  16*IP_LAYER*NUM_INP  input array; element k in bits [16k+15:16k].
- weights_flat  out  16*IP_LAYER*NUM_INP  weight array, same packing.
- dense_wt_flat  out  16*IP_LAYER  dense weight array, same packing.
- bias  out  16  signed bias.
- ot  in  16  signed layer output, combinational from the operands above.
- res_valid  out  1  result available.
- res_data  out  16  captured `ot`.
- res_ready  in  1  result consumer ready.
- busy  out  1  high in any state other than LD_IN with word count 0.

Behaviour:
- Frame order: NUM_INP*IP_LAYER input words (index 0 first), then the same count of weight words, then IP_LAYER dense weights, then 1 bias word. Total N = 2*IP_LAYER*NUM_INP + IP_LAYER + 1 words; 137 at defaults.
- FSM states: LD_IN → LD_WT → LD_DW → LD_BIAS → SETTLE → RESULT → LD_IN.
- A word transfers when s_valid && s_ready.
- s_ready is 1 in the LD_* states and 0 in SETTLE and RESULT. It is a registered-state decode and does not depend combinationally on s_valid.
- Index counter:
  - Advances per transfer and clears on each state change.
  - Moves to the next state on the transfer of the last element of the current array.
  - The accepted word is written to element [counter] of the current array on that same clock edge.
- SETTLE:
  - A down-counter loads SETTLE_CYCLES on entry and decrements each cycle.
  - When it is 0, on that edge: res_data <= ot, res_valid <= 1, state → RESULT.
  - Bias-accept to res_valid high latency = SETTLE_CYCLES+1 cycles.
- RESULT:
  - res_valid and res_data are held until res_valid && res_ready.
  - On that edge: res_valid <= 0, state → LD_IN.
  - A new frame can be accepted in the next cycle.
- Operand registers are never cleared between frames; each is overwritten as its word arrives. During loading, `ot` may be mid-update and is ignored.
- res_ready asserted outside RESULT has no effect.
- s_valid with s_ready low: word is not consumed; the source holds it.
- Arithmetic: none in this block. Words are stored verbatim as signed 16-bit.
- Reset, at any time including mid-frame or while RESULT is pending:
  - State LD_IN, counters 0.
  - All *_flat outputs, bias, res_data 0; res_valid 0.
  - s_ready is 1 in the cycle after rst deasserts.
  - A partial frame or pending result is discarded.

Optional Feature:
- Macro FC_FRAME_CHECK_EN.
- Defined:
  - Adds input s_last (1) and output frame_err (1, reset 0).
  - s_last on any transfer before the bias word: frame_err pulses high for 1 cycle, the word is discarded, state → LD_IN with counter 0.
  - Bias word accepted without s_last: frame_err pulses for 1 cycle; the frame still proceeds to SETTLE normally.
- Not defined: no s_last or frame_err ports; frame length is implied by counting only.

Test Plan:
- Defaults; stream words 1..137 with s_valid always high → inputs_flat element 0 = 1, weights_flat element 0 = 65, dense_wt element 7 = 136, bias = 137. Stub ot = 16'sd-42 → res_valid rises exactly 3 cycles after the bias accept, res_data = -42.
- res_ready held low 10 cycles after res_valid → s_ready stays 0, res_data stable. Raise res_ready → res_valid drops next edge; s_ready = 1 the following cycle.
- Random s_valid gaps (about 30% idle) over 3 back-to-back frames → every word is stored exactly once at its correct index; 3 results returned.
- Assert rst for 1 cycle after 70 words → all outputs 0, s_ready = 1 afterwards. A fresh 137-word frame completes correctly.
- s_valid high while in SETTLE/RESULT, data 16'h7FFF → no operand changes.
- With FC_FRAME_CHECK_EN: s_last on word 10 → frame_err pulse, restart at LD_IN. Bias without s_last → frame_err pulse and result still produced.
